gasid_feature_loader: RTL and testbench
=======================================

GASID_FEATURE_LOADER -- requirements
Module: gasid_feature_loader

Interface
REQ-001 SHALL provide parameter FEAT_CNT, default 128, number of input features.
REQ-002 SHALL provide parameter FEAT_BITS, default 4, bits per feature.
REQ-003 SHALL provide parameter CLASS_CNT, default 6, number of classifier classes.
REQ-004 SHALL provide parameter LANE_BITS, default 16, stream beat width; FEAT_CNT*FEAT_BITS must be a multiple of LANE_BITS, so BEATS = FEAT_CNT*FEAT_BITS/LANE_BITS (default 32).
REQ-005 SHALL provide parameter SETTLE_CYC, default 4, range 1..255, classifier settle time in cycles.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 s_valid  input  1  feature beat valid.
REQ-010 s_ready  output  1  loader accepts a beat.
REQ-011 s_data  input  LANE_BITS  feature beat; bit 0 = LSB of the lowest-index feature in the beat.
REQ-012 s_last  input  1  final beat of a feature vector.
REQ-013 features  output  FEAT_CNT*FEAT_BITS  registered vector driven into the combinational classifier.
REQ-014 prediction_in  input  $clog2(CLASS_CNT)  classifier output.
REQ-015 m_valid  output  1  result valid.
REQ-016 m_ready  input  1  result consumer ready.
REQ-017 m_class  output  $clog2(CLASS_CNT)  captured class index.
REQ-018 err_len  output  1  one-cycle pulse on a framing error.
REQ-019 err_class  output  1  high with m_valid when the captured prediction_in is >= CLASS_CNT.
REQ-020 frames_done  output  16  count of completed result handshakes; wraps 0xFFFF->0.

Function
REQ-021 SHALL implement the FSM states LOAD, SETTLE and OUT.
REQ-022 A beat SHALL be accepted on a rising edge with s_valid && s_ready; s_ready SHALL be high only in LOAD.
REQ-023 Accepted beat k (0-based) SHALL be written to features[k*LANE_BITS +: LANE_BITS], and the beat counter SHALL increment.
REQ-024 Accepting beat BEATS-1 SHALL move the FSM LOAD->SETTLE and clear the beat counter; if s_last is low on that beat, err_len SHALL pulse and the frame SHALL still proceed.
REQ-025 Accepting a beat with s_last high and k < BEATS-1 SHALL pulse err_len, clear the beat counter and keep the FSM in LOAD; the frame is dropped, with no result and no SETTLE.
REQ-026 features SHALL change only on accepted beats and SHALL be stable in SETTLE and OUT.
REQ-027 In SETTLE, the settle counter SHALL count cycles; on the SETTLE_CYC-th edge after SETTLE entry, the block SHALL register prediction_in into m_class, set err_class = (prediction_in >= CLASS_CNT), raise m_valid and enter OUT.
REQ-028 The latency from the edge accepting the last beat to m_valid high SHALL be exactly SETTLE_CYC cycles.
REQ-029 In OUT, m_valid, m_class and err_class SHALL hold until m_valid && m_ready on an edge; on that edge m_valid SHALL clear, frames_done SHALL increment, the FSM SHALL enter LOAD, and s_ready SHALL be high in the following cycle.
REQ-030 s_valid, s_data and s_last SHALL be ignored outside LOAD; m_ready SHALL be ignored outside OUT.

Reset
REQ-031 With rst_n low, the block SHALL immediately force: state LOAD; s_ready, m_valid, m_class, err_len, err_class, frames_done and features all 0; beat and settle counters 0.
REQ-032 s_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-033 A reset in any state mid-frame SHALL discard the partial frame and any pending result, with no err_len pulse.

Verification
REQ-034 Send 32 beats with s_data = beat index and s_last on beat 31, with prediction_in = 3 -> features[15:0]=0x0000 and features[511:496]=0x001F; m_valid rises 4 cycles after beat 31 is accepted, m_class=3, err_class=0, err_len never pulses.
REQ-035 Hold m_ready=0 for 10 cycles in OUT, then raise it -> m_valid and m_class stay stable, one handshake occurs, frames_done goes 0->1, and s_ready=1 in the next cycle.
REQ-036 Assert s_last on beat 5 -> err_len pulses for 1 cycle, no m_valid, and the next 32-beat frame completes normally.
REQ-037 Send 32 beats with s_last low throughout and prediction_in = 7 -> err_len pulses on beat 31, the result is still produced, m_class=7 and err_class=1.
REQ-038 Drive rst_n low in SETTLE -> m_valid stays 0, features=0, and s_ready=1 on the first edge after release; drive s_valid toggling randomly -> beats are counted only on s_valid && s_ready.
REQ-039 Preload frames_done to 0xFFFF via 65535 frames, or a forced value, and complete one more frame -> frames_done=0x0000.

Source files
------------

// File: rtl/gasid_feature_loader.sv
// Streams a feature vector into a register bank, lets a combinational
// classifier settle, then captures and hands off its prediction.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   s_valid/s_ready/s_data/s_last   feature beat stream in
//   features                registered vector to the classifier
//   prediction_in           classifier result
//   m_valid/m_ready/m_class result handshake out
//   err_len                 one-cycle framing error pulse
//   err_class               prediction out of range (with m_valid)
//   frames_done             completed result handshakes (wraps)
module gasid_feature_loader #(
  parameter int FEAT_CNT   = 128,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter int LANE_BITS  = 16,
  parameter int SETTLE_CYC = 4,
  localparam int FW = FEAT_CNT * FEAT_BITS,
  localparam int CW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LANE_BITS-1:0] s_data,
  input  logic                 s_last,
  output logic [FW-1:0]        features,
  input  logic [CW-1:0]        prediction_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        m_class,
  output logic                 err_len,
  output logic                 err_class,
  output logic [15:0]          frames_done
);

  localparam int BEATS = FW / LANE_BITS;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    OUT
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    settle_cnt;
  logic [15:0]   done_cnt;

  logic accept;
  logic last_beat;

  assign accept      = s_valid && s_ready;
  assign last_beat   = (beat_cnt == BW'(BEATS - 1));
  assign frames_done = done_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      err_len    <= 1'b0;
      err_class  <= 1'b0;
      done_cnt   <= '0;
      features   <= '0;
      beat_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      err_len <= 1'b0;
      unique case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            for (int i = 0; i < BEATS; i++) begin
              if (beat_cnt == BW'(i)) begin
                features[i*LANE_BITS +: LANE_BITS] <= s_data;
              end
            end
            if (last_beat) begin
              // Full length reached: proceed even if s_last missing.
              beat_cnt   <= '0;
              settle_cnt <= '0;
              s_ready    <= 1'b0;
              state      <= SETTLE;
              err_len    <= !s_last;
            end else if (s_last) begin
              // Short frame: drop it and restart the count.
              beat_cnt <= '0;
              err_len  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            m_class    <= prediction_in;
            err_class  <= (32'(prediction_in) >= CLASS_CNT);
            m_valid    <= 1'b1;
            state      <= OUT;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            err_class <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            s_ready   <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gasid_feature_loader.sv
// Directed bench for gasid_feature_loader: frame table plus
// hand sequences for hold, reset, random valid and counter wrap.
module tb_gasid_feature_loader;

  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [511:0]  features;
  logic [2:0]    prediction_in = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [2:0]    m_class;
  logic          err_len;
  logic          err_class;
  logic [15:0]   frames_done;

  int checks = 0;
  int failures = 0;
  int errlen_cnt = 0;
  int exp_frames = 0;

  gasid_feature_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .features(features),
    .prediction_in(prediction_in),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_class(m_class),
    .err_len(err_len),
    .err_class(err_class),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && err_len) errlen_cnt++;
  end

  typedef struct {
    int         last_idx;
    logic [2:0] pred;
    int         exp_errlen;
    bit         result;
    logic [2:0] exp_class;
    logic       exp_ec;
    int         hold;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] d,
                           input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called #1 after the edge that accepted the last beat.
  // Junk on the stream must not reach features meanwhile.
  task automatic wait_result(output int lat);
    lat = 0;
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    s_last  = 1'b1;
    while (!m_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic handshake(input int hold);
    int bad;
    logic [2:0] c0;
    bad = 0;
    c0 = m_class;
    m_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!m_valid || m_class !== c0) bad++;
    end
    if (hold > 0) chk("hold_stable", 64'(bad), 0);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    exp_frames = (exp_frames + 1) & 16'hFFFF;
    chk("hs_m_valid", 64'(m_valid), 0);
    chk("hs_frames_done", 64'(frames_done), 64'(exp_frames));
    chk("hs_s_ready", 64'(s_ready), 1);
  endtask

  initial begin
    int lat, e0, nb, bad, k, n;
    logic [15:0] x;

    vecs[0] = '{31, 3'd3, 0, 1'b1, 3'd3, 1'b0, 10};
    vecs[1] = '{5,  3'd2, 1, 1'b0, 3'd0, 1'b0, 0};
    vecs[2] = '{-1, 3'd7, 1, 1'b1, 3'd7, 1'b1, 0};
    vecs[3] = '{31, 3'd6, 0, 1'b1, 3'd6, 1'b1, 2};
    vecs[4] = '{0,  3'd1, 1, 1'b0, 3'd0, 1'b0, 0};
    vecs[5] = '{31, 3'd5, 0, 1'b1, 3'd5, 1'b0, 0};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_features", 64'(|features), 0);
    chk("rst_frames", 64'(frames_done), 0);
    chk("rst_err", 64'({err_len, err_class}), 0);
    rst_n = 1'b1;
    #1 chk("rel_s_ready_low", 64'(s_ready), 0);
    @(posedge clk);
    #1 chk("rel_s_ready_high", 64'(s_ready), 1);

    for (int i = 0; i < 6; i++) begin
      e0 = errlen_cnt;
      prediction_in = vecs[i].pred;
      m_ready = (i == 3);
      nb = (vecs[i].last_idx < 0) ? 32 : vecs[i].last_idx + 1;
      for (int b = 0; b < nb; b++) begin
        x = 16'(b) ^ 16'(i << 8);
        send_beat(x, b == vecs[i].last_idx);
      end
      m_ready = 1'b0;
      if (vecs[i].result) begin
        wait_result(lat);
        chk($sformatf("v%0d_latency", i), 64'(lat), SC);
        chk($sformatf("v%0d_class", i), 64'(m_class),
            64'(vecs[i].exp_class));
        chk($sformatf("v%0d_err_class", i),
            64'(err_class), 64'(vecs[i].exp_ec));
        x = 16'(i << 8);
        chk($sformatf("v%0d_feat_lo", i),
            64'(features[15:0]), 64'(x));
        x = 16'(31) ^ 16'(i << 8);
        chk($sformatf("v%0d_feat_hi", i),
            64'(features[511:496]), 64'(x));
        x = 16'(17) ^ 16'(i << 8);
        chk($sformatf("v%0d_feat_mid", i),
            64'(features[17*16 +: 16]), 64'(x));
        chk($sformatf("v%0d_err_len", i),
            64'(errlen_cnt - e0), 64'(vecs[i].exp_errlen));
        handshake(vecs[i].hold);
      end else begin
        bad = 0;
        repeat (8) begin
          @(negedge clk);
          if (m_valid) bad++;
        end
        chk($sformatf("v%0d_no_result", i), 64'(bad), 0);
        chk($sformatf("v%0d_s_ready", i), 64'(s_ready), 1);
        chk($sformatf("v%0d_err_len", i),
            64'(errlen_cnt - e0), 64'(vecs[i].exp_errlen));
      end
    end

    // Reset while settling.
    e0 = errlen_cnt;
    prediction_in = 3'd2;
    for (int b = 0; b < 32; b++) send_beat(16'(b + 64), 1'b0 || b == 31);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_m_valid", 64'(m_valid), 0);
    chk("mr_features", 64'(|features), 0);
    chk("mr_frames", 64'(frames_done), 0);
    exp_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mr_s_ready", 64'(s_ready), 1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid) bad++;
    end
    chk("mr_no_result", 64'(bad), 0);
    chk("mr_err_len", 64'(errlen_cnt - e0), 0);

    // Gappy stream: only valid&&ready beats count.
    prediction_in = 3'd4;
    k = 0;
    n = 0;
    while (k < 32 && n < 500) begin
      @(negedge clk);
      n++;
      if (s_ready && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b1;
        s_data  = 16'h0100 + 16'(k);
        s_last  = (k == 31);
        k++;
      end else begin
        s_valid = 1'b0;
        s_data  = 16'hDEAD;
        s_last  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("rv_beats", 64'(k), 32);
    wait_result(lat);
    chk("rv_latency", 64'(lat), SC);
    chk("rv_class", 64'(m_class), 4);
    chk("rv_feat_lo", 64'(features[15:0]), 64'h0100);
    chk("rv_feat_hi", 64'(features[511:496]), 64'h011F);
    chk("rv_feat_mid", 64'(features[9*16 +: 16]), 64'h0109);
    handshake(0);

    // Counter wrap.
    @(negedge clk);
    force dut.done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.done_cnt;
    @(negedge clk);
    chk("wrap_preload", 64'(frames_done), 64'hFFFF);
    exp_frames = 16'hFFFF;
    prediction_in = 3'd0;
    for (int b = 0; b < 32; b++) send_beat(16'(b), b == 31);
    wait_result(lat);
    chk("wrap_latency", 64'(lat), SC);
    handshake(0);
    chk("wrap_zero", 64'(frames_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
